pe_psum_acc: RTL and testbench

//  Sequential partial-sum accumulator directly downstream of the PE's 32-lane adder tree.

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_psum_post.sv | 30 +++
 rtl/pe_psum_acc.sv | 116 +++++++++++
 tb/tb_pe_psum_acc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE partial-sum path:
// width defaults, accumulator FSM states, signed-add overflow helper.
package pe_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } psum_state_e;

    // Signed add overflow from sign bits only, so it works at any width:
    // operands agree in sign but the sum does not.
    function automatic logic add_ovf(
        input logic a_s,
        input logic b_s,
        input logic s_s
    );
        return (a_s == b_s) && (s_s != a_s);
    endfunction

endpackage

// File: rtl/pe_psum_post.sv
// Combinational result stage: applies ReLU to the wrapped sum and
// drives zeros on all result fields whenever no result is presented.
// Ports: valid (result presented), relu, acc, ovf, cnt in;
//        out_data, out_ovf, out_beats out.
module pe_psum_post #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             valid,
    input  logic             relu,
    input  logic [ACC_W-1:0] acc,
    input  logic             ovf,
    input  logic [CNT_W-1:0] cnt,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_beats
);

    always_comb begin
        out_data  = '0;
        out_ovf   = 1'b0;
        out_beats = '0;
        if (valid) begin
            out_data  = (relu && acc[ACC_W-1]) ? '0 : acc;
            out_ovf   = ovf;
            out_beats = cnt;
        end
    end

endmodule

// File: rtl/pe_psum_acc.sv
// Partial-sum accumulator behind the 32-lane adder tree: sums N beats
// plus a per-vector bias, optional ReLU, valid/ready result port.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_last
//        beat stream; cfg_bias/cfg_relu sampled on a vector's first beat;
//        out_valid/out_ready/out_data/out_ovf/out_beats result stream.
module pe_psum_acc
    import pe_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    input  logic             in_last,
    input  logic [ACC_W-1:0] cfg_bias,
    input  logic             cfg_relu,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_beats
);

    psum_state_e      state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             relu_q, relu_d;

    logic             accept;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] sum;
    logic             sum_ovf;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    // First beat adds onto the bias instead of the running sum.
    assign add_a   = (state_q == IDLE) ? cfg_bias : acc_q;
    assign sum     = add_a + in_data;
    assign sum_ovf = add_ovf(add_a[ACC_W-1], in_data[ACC_W-1], sum[ACC_W-1]);
    // Beat count saturates rather than wrapping.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        relu_d  = relu_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = sum;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = sum_ovf;
                    relu_d  = cfg_relu;
                    state_d = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sum_ovf;
                    if (in_last) state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            relu_q  <= relu_d;
        end
    end

    pe_psum_post #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_post (
        .valid     (out_valid),
        .relu      (relu_q),
        .acc       (acc_q),
        .ovf       (ovf_q),
        .cnt       (cnt_q),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_beats (out_beats)
    );

endmodule

// File: tb/tb_pe_psum_acc.sv
// Directed bench for pe_psum_acc: reset, multi-beat sums, ReLU,
// overflow, backpressure and mid-vector reset.
module tb_pe_psum_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] cfg_bias;
    logic        cfg_relu;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic [15:0] out_beats;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_psum_acc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .cfg_bias  (cfg_bias),
        .cfg_relu  (cfg_relu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_beats (out_beats)
    );

    task automatic send_beat(input logic [31:0] d, input logic last,
                             input logic [31:0] bias, input logic relu);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        cfg_bias = bias;
        cfg_relu = relu;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'b0;
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 'x;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0 ||
            out_ovf !== 1'b0 || out_beats !== 16'd0) begin
            bad++;
            $display("FAIL reset: v=%b rdy=%b d=%h ovf=%b n=%0d want 0 1 0 0 0",
                     out_valid, in_ready, out_data, out_ovf, out_beats);
        end
    endtask

    task automatic test_single();
        send_beat(32'd5, 1'b1, 32'd3, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'd8 || out_beats !== 16'd1 ||
            out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL single: v=%b d=%0d n=%0d ovf=%b rdy=%b want 1 8 1 0 0",
                     out_valid, out_data, out_beats, out_ovf, in_ready);
        end
        pop();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_pop: v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic run_vec4(input logic relu);
        send_beat(32'd10, 1'b0, 32'd0, relu);
        bubble(2);
        send_beat(-32'sd20, 1'b0, 32'd100, ~relu);
        bubble(1);
        send_beat(32'd30, 1'b0, 32'd100, ~relu);
        send_beat(-32'sd40, 1'b1, 32'd100, ~relu);
    endtask

    task automatic test_multi_beat();
        run_vec4(1'b0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFEC ||
            out_beats !== 16'd4 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL multi: v=%b d=%h n=%0d ovf=%b want 1 ffffffec 4 0",
                     out_valid, out_data, out_beats, out_ovf);
        end
        pop();
    endtask

    task automatic test_relu();
        run_vec4(1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'd0 || out_beats !== 16'd4) begin
            bad++;
            $display("FAIL relu_neg: v=%b d=%h n=%0d want 1 0 4",
                     out_valid, out_data, out_beats);
        end
        pop();
        send_beat(32'd3, 1'b0, 32'd0, 1'b1);
        send_beat(32'd4, 1'b1, 32'd0, 1'b0);
        total++;
        if (out_data !== 32'd7 || out_beats !== 16'd2) begin
            bad++;
            $display("FAIL relu_pos: d=%0d n=%0d want 7 2", out_data, out_beats);
        end
        pop();
    endtask

    task automatic test_overflow();
        send_beat(32'd1, 1'b1, 32'h7FFF_FFFF, 1'b0);
        total++;
        if (out_data !== 32'h8000_0000 || out_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_pos: d=%h ovf=%b want 80000000 1", out_data, out_ovf);
        end
        pop();
        send_beat(32'd2, 1'b1, 32'd0, 1'b0);
        total++;
        if (out_data !== 32'd2 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: d=%h ovf=%b want 2 0", out_data, out_ovf);
        end
        pop();
        // Sticky across beats: wraps up then back down.
        send_beat(32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0);
        send_beat(32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0);
        total++;
        if (out_data !== 32'h7FFF_FFFF || out_ovf !== 1'b1 || out_beats !== 16'd2) begin
            bad++;
            $display("FAIL ovf_sticky: d=%h ovf=%b n=%0d want 7fffffff 1 2",
                     out_data, out_ovf, out_beats);
        end
        pop();
        // Negative overflow with ReLU: wrapped value is positive.
        send_beat(32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
        total++;
        if (out_data !== 32'h7FFF_FFFF || out_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_neg: d=%h ovf=%b want 7fffffff 1", out_data, out_ovf);
        end
        pop();
    endtask

    task automatic test_backpressure();
        send_beat(32'd6, 1'b1, 32'd0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd11;
        in_last  = 1'b1;
        cfg_bias = 32'd0;
        cfg_relu = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'd6 || out_beats !== 16'd1 ||
                in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall%0d: v=%b d=%0d n=%0d rdy=%b want 1 6 1 0",
                         i, out_valid, out_data, out_beats, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'd11 || out_beats !== 16'd1) begin
            bad++;
            $display("FAIL bp_held_beat: v=%b d=%0d n=%0d want 1 11 1",
                     out_valid, out_data, out_beats);
        end
        pop();
    endtask

    task automatic test_mid_reset();
        send_beat(32'd1, 1'b0, 32'd0, 1'b0);
        send_beat(32'd2, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0 ||
            out_ovf !== 1'b0 || out_beats !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset: v=%b rdy=%b d=%h ovf=%b n=%0d want 0 1 0 0 0",
                     out_valid, in_ready, out_data, out_ovf, out_beats);
        end
        send_beat(32'd9, 1'b1, 32'd0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'd9 || out_beats !== 16'd1) begin
            bad++;
            $display("FAIL after_reset: v=%b d=%0d n=%0d want 1 9 1",
                     out_valid, out_data, out_beats);
        end
        pop();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        cfg_bias  = '0;
        cfg_relu  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_multi_beat();
        test_relu();
        test_overflow();
        test_backpressure();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
